tt_sample_driver: RTL and testbench
===================================

# tt_sample_driver

Host-side driver for the Tiny Tapeout spike-detector tile (`tt_um_example`). It accepts 16-bit samples over a valid/ready stream and serialises each one onto the tile's byte-strobe input protocol. After a fixed processing wait it sweeps the tile's channel-select lines and captures each channel's `uo_out` byte, then returns all captured bytes as one result word over a second valid/ready stream. It sits in the FPGA or bench harness between the sample source (file reader, DMA) and the tile pins.

## Interface
- `NUM_UNITS`, default 4: number of channels scanned; legal range 1..4 (2-bit select field).
- `PROCESS_CYCLES`, default 2: idle cycles between the LSB hold and the first channel select; 0 is legal.
- `SETTLE_CYCLES`, default 1: cycles each channel select is held before `uo_out` is captured; legal range ≥1.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  sample valid.
- `s_ready`  out  1  driver can accept a sample.
- `s_data`  in  16  sample, two's complement, MSB sent first.
- `tt_ui_in`  out  8  to tile `ui_in`; bit 2 is the byte strobe, bits [1:0] are the channel select, other bits are 0.
- `tt_uio_in`  out  8  to tile `uio_in`; data byte.
- `tt_uo_out`  in  8  from tile `uo_out`.
- `r_valid`  out  1  result valid.
- `r_ready`  in  1  result consumer ready.
- `r_data`  out  8*NUM_UNITS  channel `i` is in bits [8i+7:8i].
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, MSB_STB, MSB_HOLD, LSB_STB, LSB_HOLD, WAIT, SCAN, RESULT.
- IDLE: `s_ready`=1. On `s_valid && s_ready`, latch `s_data` and go to MSB_STB.
- MSB_STB: `tt_uio_in`=data[15:8], `tt_ui_in`=0x04. Lasts 1 cycle, then MSB_HOLD.
- MSB_HOLD: `tt_uio_in` held, `tt_ui_in`=0x00. Lasts 1 cycle.
- LSB_STB and LSB_HOLD: same pattern as the MSB states, using data[7:0].
- WAIT: `tt_ui_in`=0x00 for PROCESS_CYCLES cycles. If PROCESS_CYCLES is 0, go directly from LSB_HOLD to SCAN.
- SCAN: for ch = 0..NUM_UNITS-1, drive `tt_ui_in`={6'b0, ch[1:0]} for SETTLE_CYCLES cycles. At the clock edge ending the last settle cycle, capture `tt_uo_out` into `r_data` slot `ch`. After the last channel, go to RESULT.
- RESULT: `r_valid`=1 and `tt_ui_in`=0x00. Stay until `r_ready`, then go to IDLE.
- `tt_uio_in` holds its last value outside the STB/HOLD states.
- `s_valid` asserted while `busy` is high is ignored; the source stalls on `s_ready`=0.
- Reset mid-operation aborts immediately. No partial result is emitted and the latched sample is discarded.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `tt_ui_in`=0x00, `tt_uio_in`=0x00, `r_data`=0, `r_valid`=0, `busy`=0, `s_ready`=0. `s_ready` rises on the first `clk` edge after `rst` deasserts.
- Accept happens at edge t0. MSB_STB occupies cycle t0+1, LSB_STB occupies t0+3, SCAN starts at t0+5+PROCESS_CYCLES, and `r_valid` rises at t0+5+PROCESS_CYCLES+NUM_UNITS*SETTLE_CYCLES. With default parameters `r_valid` rises at t0+11.
- Throughput: `r_ready` tied high gives one RESULT cycle, then IDLE with `s_ready`=1 on the following cycle. The minimum sample period is 7+PROCESS_CYCLES+NUM_UNITS*SETTLE_CYCLES cycles (13 at defaults).
- The strobe (bit 2) is high for exactly one cycle per byte and is never high in consecutive cycles.
- `r_data` is stable while `r_valid` is high.

## Structure
- Shared package `tt_link_pkg` holds:
  - state enum;
  - `STROBE_BIT`=2;
  - `SEL_W`=2;
  - `SAMPLE_W`=16;
  - `BYTE_W`=8.
- A single module with no sub-module. The wait counter and settle counter share one down-counter; the channel index is a separate counter.
- The tile model used by the bench reuses the same package constants.

## Test plan
- Reset release, then `s_data`=0x1234 → cycle 1 shows `tt_uio_in`=0x12 with `tt_ui_in`=0x04; cycle 3 shows `tt_uio_in`=0x34 with `tt_ui_in`=0x04; cycles 2 and 4 show `tt_ui_in`=0x00.
- Stub tile returns `uo_out`=0xA0|sel → channel selects 0x00..0x03 appear in cycles 7..10, and `r_valid` is high at cycle 11 with `r_data`=0xA3A2A1A0.
- `r_ready` held low for 5 cycles → `r_valid` and `r_data` hold; `s_ready` stays 0; `s_valid` pulses during this window are not consumed.
- Back-to-back samples 0x8000 then 0x7FFF with `r_ready`=1 → second accept occurs 13 cycles after the first; byte streams are 0x80,0x00 then 0x7F,0xFF.
- PROCESS_CYCLES=0 and SETTLE_CYCLES=2 → SCAN starts at t0+5, each select is held 2 cycles, and `r_valid` rises at t0+13.
- `rst` asserted during SCAN (ch=2) → `tt_ui_in`=0x00 asynchronously, `r_valid` never rises, and the next sample starts cleanly from MSB_STB.

Source files
------------

// File: rtl/tt_link_pkg.sv
// Shared constants and state encoding for the Tiny Tapeout spike-detector link.
// Used by the sample driver and by the tile model in the bench.
package tt_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MSB_STB,
        ST_MSB_HOLD,
        ST_LSB_STB,
        ST_LSB_HOLD,
        ST_WAIT,
        ST_SCAN,
        ST_RESULT
    } state_t;

    localparam int STROBE_BIT = 2;
    localparam int SEL_W      = 2;
    localparam int SAMPLE_W   = 16;
    localparam int BYTE_W     = 8;

endpackage

// File: rtl/tt_sample_driver.sv
// Serialises 16-bit samples onto the tile byte-strobe protocol, scans the
// channel selects after a processing wait, and returns the captured bytes.
module tt_sample_driver
    import tt_link_pkg::*;
#(
    parameter int NUM_UNITS      = 4,
    parameter int PROCESS_CYCLES = 2,
    parameter int SETTLE_CYCLES  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [SAMPLE_W-1:0]         s_data,
    output logic [BYTE_W-1:0]           tt_ui_in,
    output logic [BYTE_W-1:0]           tt_uio_in,
    input  logic [BYTE_W-1:0]           tt_uo_out,
    output logic                        r_valid,
    input  logic                        r_ready,
    output logic [BYTE_W*NUM_UNITS-1:0] r_data,
    output logic                        busy
);

    // One down-counter serves both the processing wait and the per-channel settle.
    localparam int CNT_MAX = (PROCESS_CYCLES > SETTLE_CYCLES) ? PROCESS_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] WAIT_LOAD   = CNT_W'((PROCESS_CYCLES > 0) ? PROCESS_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_CH     = SEL_W'(NUM_UNITS - 1);

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [SEL_W-1:0]              ch_q, ch_d;
    logic [SAMPLE_W-1:0]           data_q, data_d;
    logic [BYTE_W-1:0]             ui_q, ui_d;
    logic [BYTE_W-1:0]             uio_q, uio_d;
    logic [BYTE_W*NUM_UNITS-1:0]   r_data_q, r_data_d;
    logic                          r_valid_q, r_valid_d;
    logic                          busy_q, busy_d;
    logic                          s_ready_q, s_ready_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        data_d   = data_q;
        r_data_d = r_data_q;
        case (state_q)
            ST_IDLE: begin
                if (s_valid && s_ready_q) begin
                    data_d  = s_data;
                    state_d = ST_MSB_STB;
                end
            end
            ST_MSB_STB:  state_d = ST_MSB_HOLD;
            ST_MSB_HOLD: state_d = ST_LSB_STB;
            ST_LSB_STB:  state_d = ST_LSB_HOLD;
            ST_LSB_HOLD: begin
                if (PROCESS_CYCLES == 0) begin
                    state_d = ST_SCAN;
                    cnt_d   = SETTLE_LOAD;
                    ch_d    = '0;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_SCAN;
                    cnt_d   = SETTLE_LOAD;
                    ch_d    = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SCAN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    r_data_d[int'(ch_q)*BYTE_W +: BYTE_W] = tt_uo_out;
                    if (ch_q == LAST_CH) begin
                        state_d = ST_RESULT;
                    end else begin
                        ch_d  = ch_q + SEL_W'(1);
                        cnt_d = SETTLE_LOAD;
                    end
                end
            end
            ST_RESULT: begin
                if (r_valid_q && r_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        ui_d  = '0;
        uio_d = uio_q;
        case (state_d)
            ST_MSB_STB: begin
                ui_d[STROBE_BIT] = 1'b1;
                uio_d            = data_d[SAMPLE_W-1 -: BYTE_W];
            end
            ST_LSB_STB: begin
                ui_d[STROBE_BIT] = 1'b1;
                uio_d            = data_d[BYTE_W-1:0];
            end
            ST_SCAN: ui_d[SEL_W-1:0] = ch_d;
            default: ui_d = '0;
        endcase
        r_valid_d = (state_d == ST_RESULT);
        busy_d    = (state_d != ST_IDLE);
        // Ready only after a full cycle in IDLE, so a returning result leaves one gap cycle.
        s_ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            data_q    <= '0;
            ui_q      <= '0;
            uio_q     <= '0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            data_q    <= data_d;
            ui_q      <= ui_d;
            uio_q     <= uio_d;
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
            busy_q    <= busy_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign tt_ui_in  = ui_q;
    assign tt_uio_in = uio_q;
    assign r_valid   = r_valid_q;
    assign r_data    = r_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tt_sample_driver.sv
// Bench for tt_sample_driver: a default instance and a PROCESS_CYCLES=0/SETTLE_CYCLES=2
// instance share stimulus; a stub tile answers uo_out = base ^ sel.
module tb_tt_sample_driver;
    import tt_link_pkg::*;

    typedef struct {
        int          cyc;
        logic [7:0]  ui;
        logic [7:0]  uio;
        logic        rv;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, r_ready, dut_sel;
    logic [15:0] s_data;
    logic [7:0]  tile_base;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        s_ready_a, r_valid_a, busy_a, s_ready_b, r_valid_b, busy_b;
    logic [7:0]  ui_a, uio_a, uo_a, ui_b, uio_b, uo_b;
    logic [31:0] r_data_a, r_data_b;

    logic        s_ready_m, r_valid_m, busy_m;
    logic [7:0]  ui_m, uio_m;
    logic [31:0] r_data_m;

    logic [7:0]  exp_byte_q[$];
    int          acc_cyc_q[$];
    logic        prev_stb = 1'b0;
    vec_t        tbl[11];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign uo_a = tile_base ^ {{(BYTE_W-SEL_W){1'b0}}, ui_a[SEL_W-1:0]};
    assign uo_b = tile_base ^ {{(BYTE_W-SEL_W){1'b0}}, ui_b[SEL_W-1:0]};

    tt_sample_driver dut_a (
        .clk(clk), .rst(rst),
        .s_valid(s_valid && !dut_sel), .s_ready(s_ready_a), .s_data(s_data),
        .tt_ui_in(ui_a), .tt_uio_in(uio_a), .tt_uo_out(uo_a),
        .r_valid(r_valid_a), .r_ready(r_ready && !dut_sel), .r_data(r_data_a),
        .busy(busy_a)
    );

    tt_sample_driver #(.NUM_UNITS(4), .PROCESS_CYCLES(0), .SETTLE_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst),
        .s_valid(s_valid && dut_sel), .s_ready(s_ready_b), .s_data(s_data),
        .tt_ui_in(ui_b), .tt_uio_in(uio_b), .tt_uo_out(uo_b),
        .r_valid(r_valid_b), .r_ready(r_ready && dut_sel), .r_data(r_data_b),
        .busy(busy_b)
    );

    assign s_ready_m = dut_sel ? s_ready_b : s_ready_a;
    assign r_valid_m = dut_sel ? r_valid_b : r_valid_a;
    assign busy_m    = dut_sel ? busy_b    : busy_a;
    assign ui_m      = dut_sel ? ui_b      : ui_a;
    assign uio_m     = dut_sel ? uio_b     : uio_a;
    assign r_data_m  = dut_sel ? r_data_b  : r_data_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted sample must appear as MSB then LSB strobed bytes.
    always @(negedge clk) begin
        if (rst) begin
            prev_stb = 1'b0;
        end else begin
            if (s_valid && s_ready_m) begin
                exp_byte_q.push_back(s_data[15:8]);
                exp_byte_q.push_back(s_data[7:0]);
                acc_cyc_q.push_back(cyc);
            end
            if (ui_m[STROBE_BIT]) begin
                chk("strobe_consecutive", {31'b0, prev_stb}, 32'd0);
                chk("strobe_pending", {31'b0, exp_byte_q.size() > 0}, 32'd1);
                if (exp_byte_q.size() > 0) chk("strobe_byte", {24'b0, uio_m}, {24'b0, exp_byte_q.pop_front()});
            end
            prev_stb = ui_m[STROBE_BIT];
        end
    end

    // Reference timeline: cycle k after the accepting edge, derived from the protocol rules.
    function automatic void model_at(input int k, input int p, input int s, input logic [15:0] smp,
                                     output logic [7:0] ui, output logic [7:0] uio, output logic rv);
        int scan0;
        int res;
        scan0 = 5 + p;
        res   = 5 + p + 4 * s;
        ui    = 8'h00;
        rv    = 1'b0;
        uio   = (k <= 2) ? smp[15:8] : smp[7:0];
        if (k == 1 || k == 3)            ui = 8'(1 << STROBE_BIT);
        else if (k >= scan0 && k < res)  ui = 8'((k - scan0) / s);
        else if (k == res)               rv = 1'b1;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [7:0] base);
        logic [31:0] r;
        for (int ch = 0; ch < 4; ch++) r[8*ch +: 8] = base ^ 8'(ch);
        return r;
    endfunction

    task automatic send_accept(input logic [15:0] smp);
        s_data  = smp;
        s_valid = 1'b1;
        for (int i = 0; i < 60 && !s_ready_m; i++) step();
        chk("send_ready_timeout", {31'b0, s_ready_m}, 32'd1);
        step();
        s_valid = 1'b0;
    endtask

    task automatic run_trace(input logic [15:0] smp, input logic [7:0] base, input int p, input int s, input int hold);
        logic [7:0] eui, euio;
        logic       erv;
        int         len;
        tile_base = base;
        r_ready   = 1'b0;
        send_accept(smp);
        len = 5 + p + 4 * s;
        for (int k = 1; k <= len; k++) begin
            model_at(k, p, s, smp, eui, euio, erv);
            chk("trace_ui", {24'b0, ui_m}, {24'b0, eui});
            chk("trace_uio", {24'b0, uio_m}, {24'b0, euio});
            chk("trace_r_valid", {31'b0, r_valid_m}, {31'b0, erv});
            chk("trace_busy", {31'b0, busy_m}, 32'd1);
            chk("trace_s_ready", {31'b0, s_ready_m}, 32'd0);
            if (k < len) step();
        end
        chk("trace_r_data", r_data_m, model_rdata(base));
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_r_valid", {31'b0, r_valid_m}, 32'd1);
            chk("hold_r_data", r_data_m, model_rdata(base));
        end
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;
        chk("done_r_valid", {31'b0, r_valid_m}, 32'd0);
        chk("done_busy", {31'b0, busy_m}, 32'd0);
        chk("done_s_ready_gap", {31'b0, s_ready_m}, 32'd0);
        step();
        chk("done_s_ready", {31'b0, s_ready_m}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int rv_seen;
        tbl[0]  = '{1,  8'h04, 8'h12, 1'b0};
        tbl[1]  = '{2,  8'h00, 8'h12, 1'b0};
        tbl[2]  = '{3,  8'h04, 8'h34, 1'b0};
        tbl[3]  = '{4,  8'h00, 8'h34, 1'b0};
        tbl[4]  = '{5,  8'h00, 8'h34, 1'b0};
        tbl[5]  = '{6,  8'h00, 8'h34, 1'b0};
        tbl[6]  = '{7,  8'h00, 8'h34, 1'b0};
        tbl[7]  = '{8,  8'h01, 8'h34, 1'b0};
        tbl[8]  = '{9,  8'h02, 8'h34, 1'b0};
        tbl[9]  = '{10, 8'h03, 8'h34, 1'b0};
        tbl[10] = '{11, 8'h00, 8'h34, 1'b1};

        rst = 1'b1; s_valid = 1'b0; r_ready = 1'b0; s_data = '0; dut_sel = 1'b0; tile_base = 8'hA0;
        step();
        step();
        chk("rst_ui", {24'b0, ui_a}, 32'd0);
        chk("rst_uio", {24'b0, uio_a}, 32'd0);
        chk("rst_r_data", r_data_a, 32'd0);
        chk("rst_r_valid", {31'b0, r_valid_a}, 32'd0);
        chk("rst_busy", {31'b0, busy_a}, 32'd0);
        chk("rst_s_ready", {31'b0, s_ready_a}, 32'd0);
        chk("rst_s_ready_b", {31'b0, s_ready_b}, 32'd0);
        rst = 1'b0;
        step();
        chk("s_ready_after_rst", {31'b0, s_ready_a}, 32'd1);

        // Directed 0x1234 timeline against the vector table, result held for 5 cycles.
        acc_cyc_q.delete();
        send_accept(16'h1234);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) step();
            chk($sformatf("tbl%0d_ui", tbl[i].cyc), {24'b0, ui_a}, {24'b0, tbl[i].ui});
            chk($sformatf("tbl%0d_uio", tbl[i].cyc), {24'b0, uio_a}, {24'b0, tbl[i].uio});
            chk($sformatf("tbl%0d_r_valid", tbl[i].cyc), {31'b0, r_valid_a}, {31'b0, tbl[i].rv});
        end
        chk("tbl_r_data", r_data_a, 32'hA3A2A1A0);
        for (int h = 1; h <= 5; h++) begin
            step();
            s_valid = h[0];
            s_data  = 16'hBEEF;
            chk("stall_r_valid", {31'b0, r_valid_a}, 32'd1);
            chk("stall_r_data", r_data_a, 32'hA3A2A1A0);
            chk("stall_s_ready", {31'b0, s_ready_a}, 32'd0);
        end
        s_valid = 1'b0;
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;
        chk("stall_release_r_valid", {31'b0, r_valid_a}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_no_new_sample", {24'b0, ui_a}, 32'd0);
        end
        chk("stall_accept_count", acc_cyc_q.size(), 32'd1);

        // Back-to-back samples with r_ready tied high.
        acc_cyc_q.delete();
        r_ready = 1'b1;
        tile_base = 8'($urandom_range(0, 255));
        s_data = 16'h8000;
        s_valid = 1'b1;
        for (int i = 0; i < 40 && acc_cyc_q.size() < 1; i++) step();
        step();
        s_data = 16'h7FFF;
        for (int i = 0; i < 40 && acc_cyc_q.size() < 2; i++) step();
        step();
        s_valid = 1'b0;
        chk("b2b_accepts", acc_cyc_q.size(), 32'd2);
        if (acc_cyc_q.size() >= 2) chk("b2b_period", 32'(acc_cyc_q[1] - acc_cyc_q[0]), 32'd13);
        for (int i = 0; i < 40 && busy_a; i++) step();
        chk("b2b_idle", {31'b0, busy_a}, 32'd0);
        r_ready = 1'b0;
        step();

        // Short-wait, long-settle instance.
        dut_sel = 1'b1;
        step();
        run_trace(16'h5AC3, 8'hA0, 0, 2, 1);
        dut_sel = 1'b0;
        step();

        // Reset asserted while channel 2 is selected.
        send_accept(16'h0F0F);
        for (int i = 0; i < 8; i++) step();
        chk("abort_ch2_sel", {24'b0, ui_a}, 32'h02);
        rst = 1'b1;
        #1;
        chk("abort_ui_async", {24'b0, ui_a}, 32'd0);
        chk("abort_busy", {31'b0, busy_a}, 32'd0);
        chk("abort_s_ready", {31'b0, s_ready_a}, 32'd0);
        step();
        step();
        rst = 1'b0;
        rv_seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (r_valid_a) rv_seen++;
        end
        chk("abort_no_result", rv_seen, 32'd0);
        run_trace(16'h1357, 8'h5C, 2, 1, 0);

        // Randomised samples, tile responses and consumer stalls on both instances.
        for (int t = 0; t < 20; t++) begin
            dut_sel = (t >= 15);
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
            if (dut_sel) run_trace(16'($urandom), 8'($urandom_range(0, 255)), 0, 2, $urandom_range(0, 3));
            else         run_trace(16'($urandom), 8'($urandom_range(0, 255)), 2, 1, $urandom_range(0, 3));
        end
        step();
        chk("bytes_drained", exp_byte_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
